// File: rtl/qblock_pkg.sv
// Shared types and constants for the question-block tracker and its bump animator.
package qblock_pkg;

    // Bump animation phases
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } bump_state_t;

    // Room select encoding used on hit_room / bump_room
    typedef enum logic {
        ROOM1 = 1'b0,
        ROOM3 = 1'b1
    } room_t;

    localparam int unsigned QBLOCK_MAX_COINS = 10;
    localparam int unsigned BUMP_OFFSET_W    = 5;

endpackage

// File: rtl/qblock_bump_anim.sv
// Bump animation for a struck question block: rises by BUMP_STEP per frame for
// half of BUMP_FRAMES, then falls back to zero over the other half.
module qblock_bump_anim
    import qblock_pkg::*;
#(
    parameter int unsigned BUMP_FRAMES = 8,
    parameter int unsigned BUMP_STEP   = 2
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     frame_tick,
    output logic                     active,
    output logic [BUMP_OFFSET_W-1:0] offset
);

    localparam int unsigned HALF  = BUMP_FRAMES / 2;
    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0]         LAST = CNT_W'(HALF - 1);
    localparam logic [BUMP_OFFSET_W-1:0] STEP = BUMP_OFFSET_W'(BUMP_STEP);

    // Reject configurations the animation cannot represent
    if (BUMP_FRAMES == 0 || (BUMP_FRAMES % 2) != 0) begin : g_bad_frames
        $error("BUMP_FRAMES must be a non-zero even number");
    end
    if (BUMP_STEP * HALF >= (1 << BUMP_OFFSET_W)) begin : g_bad_peak
        $error("Peak bump offset does not fit in BUMP_OFFSET_W bits");
    end

    bump_state_t              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BUMP_OFFSET_W-1:0] offset_q, offset_d;

    // Next-state: ticks are only counted once the FSM has left IDLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        if (clear) begin
            state_d  = IDLE;
            cnt_d    = '0;
            offset_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = RISE;
                        cnt_d    = '0;
                        offset_d = '0;
                    end
                end
                RISE: begin
                    if (frame_tick) begin
                        offset_d = offset_q + STEP;
                        if (cnt_q == LAST) begin
                            state_d = FALL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                FALL: begin
                    if (frame_tick) begin
                        if (cnt_q == LAST) begin
                            state_d  = IDLE;
                            cnt_d    = '0;
                            offset_d = '0;
                        end else begin
                            offset_d = offset_q - STEP;
                            cnt_d    = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    offset_d = '0;
                end
            endcase
        end
    end

    // State, frame counter and offset registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
        end
    end

    assign active = (state_q != IDLE);
    assign offset = offset_q;

endmodule

// File: rtl/question_block_tracker.sv
// Question-block hit/empty tracker for rooms 1 and 3: stores empty flags, takes
// head-hit events, pulses coin_spawn and drives the bump animation.
// Optional build macro: QBLOCK_MULTI_COIN_EN (multi-coin blocks with per-block counters).
module question_block_tracker
    import qblock_pkg::*;
#(
    parameter int unsigned BLOCKS_PER_ROOM = 16,
    parameter int unsigned BUMP_FRAMES     = 8,
    parameter int unsigned BUMP_STEP       = 2,
`ifdef QBLOCK_MULTI_COIN_EN
    parameter logic [BLOCKS_PER_ROOM-1:0] MULTI_COIN_MASK_ROOM1 = '0,
    parameter logic [BLOCKS_PER_ROOM-1:0] MULTI_COIN_MASK_ROOM3 = '0,
`endif
    parameter int unsigned IDX_W = (BLOCKS_PER_ROOM > 1) ? $clog2(BLOCKS_PER_ROOM) : 1
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_tick,
    input  logic                     level_clear,
    input  logic                     hit_valid,
    output logic                     hit_ready,
    input  logic                     hit_room,
    input  logic [IDX_W-1:0]         hit_index,
    input  logic [IDX_W-1:0]         query_index_room1,
    input  logic [IDX_W-1:0]         query_index_room3,
    output logic                     empty_question_room1,
    output logic                     empty_question_room3,
    output logic                     coin_spawn,
    output logic                     bump_active,
    output logic                     bump_room,
    output logic [IDX_W-1:0]         bump_index,
    output logic [BUMP_OFFSET_W-1:0] bump_offset
);

    logic [BLOCKS_PER_ROOM-1:0] flags1_q, flags1_d, flags3_q, flags3_d;
    logic                       coin_q, coin_d;
    logic                       bump_room_q, bump_room_d;
    logic [IDX_W-1:0]           bump_index_q, bump_index_d;
    logic                       hit_ok, q1_ok, q3_ok;
    logic                       cur_empty, accept, fresh, last_coin;

    // Index range checks only matter when the room size is not a power of two
    if ((1 << IDX_W) == BLOCKS_PER_ROOM) begin : g_pow2
        assign hit_ok = 1'b1;
        assign q1_ok  = 1'b1;
        assign q3_ok  = 1'b1;
    end else begin : g_npow2
        assign hit_ok = (32'(hit_index) < BLOCKS_PER_ROOM);
        assign q1_ok  = (32'(query_index_room1) < BLOCKS_PER_ROOM);
        assign q3_ok  = (32'(query_index_room3) < BLOCKS_PER_ROOM);
    end

    assign empty_question_room1 = q1_ok ? flags1_q[query_index_room1] : 1'b0;
    assign empty_question_room3 = q3_ok ? flags3_q[query_index_room3] : 1'b0;

    assign hit_ready = !bump_active && !level_clear;
    assign cur_empty = hit_ok ? ((room_t'(hit_room) == ROOM3) ? flags3_q[hit_index]
                                                              : flags1_q[hit_index]) : 1'b0;
    assign accept    = hit_valid && hit_ready && hit_ok;
    // A hit on a block that still has a coin: spawn a coin and bump it
    assign fresh     = accept && !cur_empty;

`ifdef QBLOCK_MULTI_COIN_EN
    logic [3:0] coins1_q [BLOCKS_PER_ROOM];
    logic [3:0] coins1_d [BLOCKS_PER_ROOM];
    logic [3:0] coins3_q [BLOCKS_PER_ROOM];
    logic [3:0] coins3_d [BLOCKS_PER_ROOM];
    logic       masked;
    logic [3:0] coins_cur;

    assign masked    = (room_t'(hit_room) == ROOM3) ? MULTI_COIN_MASK_ROOM3[hit_index]
                                                    : MULTI_COIN_MASK_ROOM1[hit_index];
    assign coins_cur = (room_t'(hit_room) == ROOM3) ? coins3_q[hit_index] : coins1_q[hit_index];
    // Multi-coin blocks only go empty when their last coin is released
    assign last_coin = !masked || (coins_cur == 4'd1);

    // Coin counters: reload on level_clear, decrement on each coin from a masked block
    always_comb begin
        coins1_d = coins1_q;
        coins3_d = coins3_q;
        if (level_clear) begin
            for (int i = 0; i < int'(BLOCKS_PER_ROOM); i++) begin
                coins1_d[i] = 4'(QBLOCK_MAX_COINS);
                coins3_d[i] = 4'(QBLOCK_MAX_COINS);
            end
        end else if (fresh && masked) begin
            if (room_t'(hit_room) == ROOM3) begin
                coins3_d[hit_index] = coins_cur - 4'd1;
            end else begin
                coins1_d[hit_index] = coins_cur - 4'd1;
            end
        end
    end

    // Coin counter registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(BLOCKS_PER_ROOM); i++) begin
                coins1_q[i] <= 4'(QBLOCK_MAX_COINS);
                coins3_q[i] <= 4'(QBLOCK_MAX_COINS);
            end
        end else begin
            coins1_q <= coins1_d;
            coins3_q <= coins3_d;
        end
    end
`else
    assign last_coin = 1'b1;
`endif

    // Empty-flag next state: level_clear restores every block
    always_comb begin
        flags1_d = flags1_q;
        flags3_d = flags3_q;
        if (level_clear) begin
            flags1_d = '0;
            flags3_d = '0;
        end else if (fresh && last_coin) begin
            if (room_t'(hit_room) == ROOM3) begin
                flags3_d[hit_index] = 1'b1;
            end else begin
                flags1_d[hit_index] = 1'b1;
            end
        end
    end

    // Coin pulse and latched identity of the block being animated
    always_comb begin
        coin_d       = fresh;
        bump_room_d  = fresh ? hit_room : bump_room_q;
        bump_index_d = fresh ? hit_index : bump_index_q;
    end

    // Flag storage, coin pulse and bump identity registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flags1_q     <= '0;
            flags3_q     <= '0;
            coin_q       <= 1'b0;
            bump_room_q  <= 1'b0;
            bump_index_q <= '0;
        end else begin
            flags1_q     <= flags1_d;
            flags3_q     <= flags3_d;
            coin_q       <= coin_d;
            bump_room_q  <= bump_room_d;
            bump_index_q <= bump_index_d;
        end
    end

    assign coin_spawn = coin_q;
    assign bump_room  = bump_room_q;
    assign bump_index = bump_index_q;

    qblock_bump_anim #(
        .BUMP_FRAMES (BUMP_FRAMES),
        .BUMP_STEP   (BUMP_STEP)
    ) u_bump_anim (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .start      (fresh),
        .clear      (level_clear),
        .frame_tick (frame_tick),
        .active     (bump_active),
        .offset     (bump_offset)
    );

endmodule

// File: tb/tb_question_block_tracker.sv
// Self-checking bench for question_block_tracker: reset checks, a per-cycle
// vector table, a reset-mid-animation sequence and (with QBLOCK_MULTI_COIN_EN)
// a multi-coin sequence.
module tb_question_block_tracker;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_tick, level_clear, hit_valid, hit_room;
    logic [3:0] hit_index, query_index_room1, query_index_room3;
    logic       hit_ready, empty_question_room1, empty_question_room3;
    logic       coin_spawn, bump_active, bump_room;
    logic [3:0] bump_index;
    logic [4:0] bump_offset;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

`ifdef QBLOCK_MULTI_COIN_EN
    question_block_tracker #(
        .MULTI_COIN_MASK_ROOM1 (16'h0001)
    ) dut (
`else
    question_block_tracker dut (
`endif
        .Clk                  (Clk),
        .Reset_n              (Reset_n),
        .frame_tick           (frame_tick),
        .level_clear          (level_clear),
        .hit_valid            (hit_valid),
        .hit_ready            (hit_ready),
        .hit_room             (hit_room),
        .hit_index            (hit_index),
        .query_index_room1    (query_index_room1),
        .query_index_room3    (query_index_room3),
        .empty_question_room1 (empty_question_room1),
        .empty_question_room3 (empty_question_room3),
        .coin_spawn           (coin_spawn),
        .bump_active          (bump_active),
        .bump_room            (bump_room),
        .bump_index           (bump_index),
        .bump_offset          (bump_offset)
    );

    typedef struct {
        logic       hv;
        logic       hr;
        logic [3:0] hi;
        logic       ft;
        logic       lc;
        logic [3:0] q1;
        logic [3:0] q3;
        logic       rdy;
        logic       e1;
        logic       e3;
        logic       coin;
        logic       act;
        logic [4:0] off;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic hv, input logic hr, input logic [3:0] hi,
                               input logic ft, input logic lc, input logic [3:0] q1,
                               input logic [3:0] q3, input logic rdy, input logic e1,
                               input logic e3, input logic coin, input logic act,
                               input logic [4:0] off);
        vec_t r;
        r.hv = hv; r.hr = hr; r.hi = hi; r.ft = ft; r.lc = lc; r.q1 = q1; r.q3 = q3;
        r.rdy = rdy; r.e1 = e1; r.e3 = e3; r.coin = coin; r.act = act; r.off = off;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        frame_tick = 1'b0; level_clear = 1'b0; hit_valid = 1'b0; hit_room = 1'b0;
        hit_index = '0; query_index_room1 = '0; query_index_room3 = '0;

        // hv hr hi ft lc q1 q3 | rdy e1 e3 coin act off
        vecs.push_back(v(1, 1, 5, 1, 0, 5, 5,  1, 0, 0, 0, 0, 0)); // hit r3/5, tick ignored
        vecs.push_back(v(0, 0, 0, 0, 0, 5, 5,  0, 0, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 5, 4,  0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 5,  0, 0, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 5,  0, 0, 1, 0, 1, 2));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 5,  0, 0, 1, 0, 1, 4));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 5,  0, 0, 1, 0, 1, 6));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 5,  0, 0, 1, 0, 1, 8));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 5,  0, 0, 1, 0, 1, 6));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 5,  0, 0, 1, 0, 1, 4));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 5,  0, 0, 1, 0, 1, 2));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 5,  1, 0, 1, 0, 0, 0));
        vecs.push_back(v(1, 1, 5, 0, 0, 0, 5,  1, 0, 1, 0, 0, 0)); // re-hit empty block
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 5,  1, 0, 1, 0, 0, 0));
        vecs.push_back(v(1, 0, 2, 0, 0, 2, 5,  1, 0, 1, 0, 0, 0)); // hit r1/2
        vecs.push_back(v(0, 0, 0, 1, 0, 2, 5,  0, 1, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 2, 5,  0, 1, 1, 0, 1, 2));
        vecs.push_back(v(1, 0, 7, 1, 0, 7, 5,  0, 0, 1, 0, 1, 4)); // dropped hit mid-bump
        vecs.push_back(v(0, 0, 0, 1, 0, 7, 5,  0, 0, 1, 0, 1, 6));
        vecs.push_back(v(0, 0, 0, 1, 0, 7, 5,  0, 0, 1, 0, 1, 8));
        vecs.push_back(v(0, 0, 0, 1, 0, 7, 5,  0, 0, 1, 0, 1, 6));
        vecs.push_back(v(0, 0, 0, 1, 0, 7, 5,  0, 0, 1, 0, 1, 4));
        vecs.push_back(v(0, 0, 0, 1, 0, 7, 5,  0, 0, 1, 0, 1, 2));
        vecs.push_back(v(1, 0, 7, 0, 0, 7, 5,  1, 0, 1, 0, 0, 0)); // retry accepted
        vecs.push_back(v(0, 0, 0, 0, 0, 7, 5,  0, 1, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 7, 5,  0, 1, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 7, 5,  0, 1, 1, 0, 1, 0));
        vecs.push_back(v(1, 0, 2, 0, 1, 2, 5,  0, 1, 1, 0, 1, 2)); // level_clear mid-rise
        vecs.push_back(v(0, 0, 0, 0, 0, 2, 5,  1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 2, 0, 1, 7, 5,  0, 0, 0, 0, 0, 0)); // level_clear beats hit
        vecs.push_back(v(0, 0, 0, 0, 0, 2, 5,  1, 0, 0, 0, 0, 0));

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("in_reset hit_ready", 32'(hit_ready), 1);
        chk("in_reset bump_offset", 32'(bump_offset), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        next_cycle();
        chk("reset coin_spawn", 32'(coin_spawn), 0);
        chk("reset bump_active", 32'(bump_active), 0);
        chk("reset bump_room", 32'(bump_room), 0);
        chk("reset bump_index", 32'(bump_index), 0);
        chk("reset bump_offset", 32'(bump_offset), 0);
        chk("reset hit_ready", 32'(hit_ready), 1);
        for (int i = 0; i < 16; i++) begin
            query_index_room1 = 4'(i);
            query_index_room3 = 4'(i);
            #0.5;
            chk($sformatf("reset empty1[%0d]", i), 32'(empty_question_room1), 0);
            chk($sformatf("reset empty3[%0d]", i), 32'(empty_question_room3), 0);
        end
        next_cycle();

        // Vector table: inputs applied just after a rising edge, outputs checked at the falling edge
        for (int i = 0; i < vecs.size(); i++) begin
            hit_valid = vecs[i].hv; hit_room = vecs[i].hr; hit_index = vecs[i].hi;
            frame_tick = vecs[i].ft; level_clear = vecs[i].lc;
            query_index_room1 = vecs[i].q1; query_index_room3 = vecs[i].q3;
            @(negedge Clk);
            chk($sformatf("row%0d hit_ready", i), 32'(hit_ready), 32'(vecs[i].rdy));
            chk($sformatf("row%0d empty1", i), 32'(empty_question_room1), 32'(vecs[i].e1));
            chk($sformatf("row%0d empty3", i), 32'(empty_question_room3), 32'(vecs[i].e3));
            chk($sformatf("row%0d coin_spawn", i), 32'(coin_spawn), 32'(vecs[i].coin));
            chk($sformatf("row%0d bump_active", i), 32'(bump_active), 32'(vecs[i].act));
            chk($sformatf("row%0d bump_offset", i), 32'(bump_offset), 32'(vecs[i].off));
            next_cycle();
        end
        hit_valid = 1'b0; frame_tick = 1'b0; level_clear = 1'b0;

        // Reset asserted mid-RISE aborts the animation immediately
        hit_valid = 1'b1; hit_room = 1'b1; hit_index = 4'd1; query_index_room3 = 4'd1;
        next_cycle();
        hit_valid = 1'b0;
        chk("rst_seq coin_spawn", 32'(coin_spawn), 1);
        chk("rst_seq bump_room", 32'(bump_room), 1);
        chk("rst_seq bump_index", 32'(bump_index), 1);
        frame_tick = 1'b1;
        next_cycle();
        next_cycle();
        frame_tick = 1'b0;
        chk("rst_seq offset before reset", 32'(bump_offset), 4);
        chk("rst_seq empty3 before reset", 32'(empty_question_room3), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_seq hit_ready", 32'(hit_ready), 1);
        chk("rst_seq bump_active", 32'(bump_active), 0);
        chk("rst_seq bump_offset", 32'(bump_offset), 0);
        chk("rst_seq bump_room after", 32'(bump_room), 0);
        chk("rst_seq bump_index after", 32'(bump_index), 0);
        chk("rst_seq empty3 after", 32'(empty_question_room3), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        next_cycle();

`ifdef QBLOCK_MULTI_COIN_EN
        // Room 1 block 0 is multi-coin: ten coins, empty only after the tenth
        query_index_room1 = 4'd0;
        for (int k = 1; k <= 11; k++) begin
            hit_valid = 1'b1; hit_room = 1'b0; hit_index = 4'd0;
            next_cycle();
            hit_valid = 1'b0;
            chk($sformatf("multi hit%0d coin", k), 32'(coin_spawn), (k <= 10) ? 1 : 0);
            chk($sformatf("multi hit%0d empty1", k), 32'(empty_question_room1),
                (k >= 10) ? 1 : 0);
            if (k <= 10) begin
                frame_tick = 1'b1;
                repeat (8) next_cycle();
                frame_tick = 1'b0;
            end
            chk($sformatf("multi hit%0d idle", k), 32'(bump_active), 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
